// File: rtl/ifu_fetch_if.sv
// Instruction-memory read bus between the fetch stage (master) and the memory (slave).
// The address is combinational into the memory and the instruction/fault return in the same cycle.
interface ifu_fetch_if;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic [4:0]  imexc_i;

  modport master (output pc_o, input instr_i, input imexc_i);
  modport slave  (input pc_o, output instr_i, output imexc_i);
endinterface

// File: rtl/ifu_fetch.sv
// Fetch stage: owns the PC, reads the instruction memory combinationally and loads the F/D register.
// Priority per edge: exception entry, eret, stall, redirect, sequential fetch.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [4:0]  ADEL_CODE  = 5'd4
) (
  input  logic              clk,
  input  logic              reset,
  ifu_fetch_if.master       imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              d_is_jb,
  input  logic              exc_req,
  input  logic              eret,
  input  logic [31:0]       epc,
  output logic [31:0]       d_instr,
  output logic [31:0]       d_pc,
  output logic [4:0]        d_exccode,
  output logic              d_bd
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic [4:0]  d_exccode_q, d_exccode_d;
  logic        d_bd_q, d_bd_d;
  logic        fetch_fault;

  assign fetch_fault = (imem.imexc_i != 5'd0);

  always_comb begin
    pc_d        = pc_q;
    d_instr_d   = d_instr_q;
    d_pc_d      = d_pc_q;
    d_exccode_d = d_exccode_q;
    d_bd_d      = d_bd_q;
    if (exc_req) begin
      pc_d        = HANDLER_PC;
      d_instr_d   = 32'd0;
      d_pc_d      = HANDLER_PC;
      d_exccode_d = 5'd0;
      d_bd_d      = 1'b0;
    end else if (eret) begin
      pc_d        = epc;
      d_instr_d   = 32'd0;
      d_pc_d      = epc;
      d_exccode_d = 5'd0;
      d_bd_d      = 1'b0;
    end else if (!stall) begin
      // A redirect during a stall is dropped; D still holds the branch and re-asserts it.
      pc_d        = redirect ? redirect_pc : (pc_q + 32'd4);
      d_instr_d   = fetch_fault ? 32'd0 : imem.instr_i;
      d_pc_d      = pc_q;
      d_exccode_d = imem.imexc_i;
      d_bd_d      = d_is_jb;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      d_instr_q   <= 32'd0;
      d_pc_q      <= RESET_PC;
      d_exccode_q <= 5'd0;
      d_bd_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      d_instr_q   <= d_instr_d;
      d_pc_q      <= d_pc_d;
      d_exccode_q <= d_exccode_d;
      d_bd_q      <= d_bd_d;
    end
  end

  assign imem.pc_o = pc_q;
  assign d_instr   = d_instr_q;
  assign d_pc      = d_pc_q;
  assign d_exccode = d_exccode_q;
  assign d_bd      = d_bd_q;

  // CP0 never raises an exception and commits an eret in the same cycle.
  a_exc_eret_exclusive: assert property (@(posedge clk) disable iff (reset) !(exc_req && eret));

  // The memory only ever reports "no fault" or a bad fetch address.
  a_imexc_legal: assert property (@(posedge clk) disable iff (reset)
                                  (imem.imexc_i == 5'd0) || (imem.imexc_i == ADEL_CODE));

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed test of ifu_fetch: stimulus pushes hand-computed expectations into a scoreboard
// queue and a negedge monitor pops and compares them against the DUT outputs.
module tb_ifu_fetch;

  logic        clk;
  logic        reset;
  logic        stall, redirect, d_is_jb, exc_req, eret;
  logic [31:0] redirect_pc, epc;
  logic [31:0] d_instr, d_pc;
  logic [4:0]  d_exccode;
  logic        d_bd;

  int checks = 0;
  int errors = 0;

  ifu_fetch_if imem ();

  ifu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem.master),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .d_is_jb     (d_is_jb),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .d_instr     (d_instr),
    .d_pc        (d_pc),
    .d_exccode   (d_exccode),
    .d_bd        (d_bd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: 0x3C010001 at 0x3000, incrementing by one per word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h3C01_0001 + ((a - 32'h0000_3000) >> 2);
  endfunction

  // Misaligned fetches fault; the garbage data must never reach d_instr.
  always_comb begin
    if (imem.pc_o[1:0] != 2'b00) begin
      imem.imexc_i = 5'd4;
      imem.instr_i = 32'hDEAD_BEEF;
    end else begin
      imem.imexc_i = 5'd0;
      imem.instr_i = mem_word(imem.pc_o);
    end
  end

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] dpc;
    logic [4:0]  exc;
    logic        bd;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input string nm, input logic [31:0] e_pc, input logic [31:0] e_instr,
                          input logic [31:0] e_dpc, input logic [4:0] e_exc, input logic e_bd);
    exp_t e;
    e.name  = nm;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.dpc   = e_dpc;
    e.exc   = e_exc;
    e.bd    = e_bd;
    sb.push_back(e);
  endtask

  // Called at posedge+1: drive inputs, let one edge happen, then queue what should be visible.
  task automatic cyc(input string nm, input logic st, input logic rd, input logic [31:0] rpc,
                     input logic jb, input logic ex, input logic er, input logic [31:0] ep,
                     input logic [31:0] e_pc, input logic [31:0] e_instr,
                     input logic [31:0] e_dpc, input logic [4:0] e_exc, input logic e_bd);
    stall = st; redirect = rd; redirect_pc = rpc; d_is_jb = jb;
    exc_req = ex; eret = er; epc = ep;
    @(posedge clk);
    #1;
    push_exp(nm, e_pc, e_instr, e_dpc, e_exc, e_bd);
  endtask

  task automatic chk(input string nm, input string field, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s actual=%h required=%h", nm, field, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("txn %-12s pc_o=%h d_instr=%h d_pc=%h d_exccode=%0d d_bd=%0b",
               e.name, imem.pc_o, d_instr, d_pc, d_exccode, d_bd);
      chk(e.name, "pc_o",      imem.pc_o,          e.pc);
      chk(e.name, "d_instr",   d_instr,            e.instr);
      chk(e.name, "d_pc",      d_pc,               e.dpc);
      chk(e.name, "d_exccode", {27'd0, d_exccode}, {27'd0, e.exc});
      chk(e.name, "d_bd",      {31'd0, d_bd},      {31'd0, e.bd});
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; d_is_jb = 1'b0;
    exc_req = 1'b0; eret = 1'b0; epc = 32'd0;
    #1;
    push_exp("reset", 32'h3000, 32'd0, 32'h3000, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //    name          st rd rpc            jb ex er epc           pc             instr                  dpc            exc bd
    cyc("free1",      0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h3004,     32'h3C01_0001,         32'h3000,     0, 0);
    cyc("free2",      0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h3008,     32'h3C01_0002,         32'h3004,     0, 0);
    cyc("branch",     0, 1, 32'h3040,     1, 0, 0, 32'h0,    32'h3040,     32'h3C01_0003,         32'h3008,     0, 1);
    cyc("target",     0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h3044,     mem_word(32'h3040),    32'h3040,     0, 0);
    cyc("stall1",     1, 1, 32'h3080,     0, 0, 0, 32'h0,    32'h3044,     mem_word(32'h3040),    32'h3040,     0, 0);
    cyc("stall2",     1, 1, 32'h3080,     0, 0, 0, 32'h0,    32'h3044,     mem_word(32'h3040),    32'h3040,     0, 0);
    cyc("stall3",     1, 1, 32'h3080,     0, 0, 0, 32'h0,    32'h3044,     mem_word(32'h3040),    32'h3040,     0, 0);
    cyc("release",    0, 1, 32'h3080,     1, 0, 0, 32'h0,    32'h3080,     mem_word(32'h3044),    32'h3044,     0, 1);
    cyc("misalign",   0, 1, 32'h3002,     0, 0, 0, 32'h0,    32'h3002,     mem_word(32'h3080),    32'h3080,     0, 0);
    cyc("fault",      0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h3006,     32'd0,                 32'h3002,     4, 0);
    cyc("fault2",     0, 1, 32'h3100,     0, 0, 0, 32'h0,    32'h3100,     32'd0,                 32'h3006,     4, 0);
    cyc("exc_stall",  1, 0, 32'h0,        1, 1, 0, 32'h0,    32'h4180,     32'd0,                 32'h4180,     0, 0);
    cyc("eret",       0, 0, 32'h0,        1, 0, 1, 32'h3104, 32'h3104,     32'd0,                 32'h3104,     0, 0);
    cyc("after_eret", 0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h3108,     mem_word(32'h3104),    32'h3104,     0, 0);
    cyc("eret_stall", 1, 1, 32'h3300,     0, 0, 1, 32'h3200, 32'h3200,     32'd0,                 32'h3200,     0, 0);
    cyc("bd_seq",     0, 0, 32'h0,        1, 0, 0, 32'h0,    32'h3204,     mem_word(32'h3200),    32'h3200,     0, 1);
    cyc("to_top",     0, 1, 32'hFFFF_FFFC,0, 0, 0, 32'h0,    32'hFFFF_FFFC,mem_word(32'h3204),    32'h3204,     0, 0);
    cyc("wrap",       0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h0000_0000,mem_word(32'hFFFF_FFFC),32'hFFFF_FFFC,0, 0);

    // One stalled edge with no expectation, then reset mid-cycle, checked before the next edge.
    stall = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b1;
    push_exp("async_rst", 32'h3000, 32'd0, 32'h3000, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    push_exp("rst_held", 32'h3000, 32'd0, 32'h3000, 5'd0, 1'b0);
    reset = 1'b0;
    cyc("post_rst",   0, 0, 32'h0,        0, 0, 0, 32'h0,    32'h3004,     32'h3C01_0001,         32'h3000,     0, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
